chunk_serial_addsub: RTL and testbench

- Parametrised multi-cycle add/subtract unit for the ALU path; successor to the fixed 32-bit conditional operand inverter.
- Conditionally inverts operand B for subtraction, then adds CHUNK bits per cycle with a registered carry chain.
- Produces result plus C/V/Z/N flags under a START/BUSY/DONE handshake.
- Used where a full-width single-cycle carry chain misses timing, or for area-reduced variants.

---
 rtl/chunk_serial_addsub.sv | 144 ++++++++++++++
 tb/tb_chunk_serial_addsub.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/chunk_serial_addsub.sv
// Multi-cycle add/subtract: B is conditionally inverted, then CHUNK bits are summed per cycle.
// Optional signed saturation on overflow when ADDSUB_SATURATE_EN is defined.
module chunk_serial_addsub #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned CHUNK = 8
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             START,
   input  logic             SUB,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   output logic             BUSY,
   output logic             DONE,
   output logic [WIDTH-1:0] RESULT,
   output logic             CARRY,
   output logic             OVERFLOW,
   output logic             ZERO,
   output logic             NEGATIVE
);

   localparam int unsigned NCHUNK = WIDTH / CHUNK;
   localparam int unsigned CNT_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NCHUNK - 1);

   typedef enum logic [1:0] {StIdle, StRun, StFin} state_e;

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             carry_q, carry_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] bx_q, bx_d;
   logic [WIDTH-1:0] shadow_q, shadow_d;
   logic [WIDTH-1:0] result_q, result_d;
   logic             cflag_q, cflag_d;
   logic             vflag_q, vflag_d;
   logic             zflag_q, zflag_d;
   logic             nflag_q, nflag_d;

   logic [CHUNK:0]   chunk_sum;
   logic [WIDTH-1:0] raw_sum;
   logic [WIDTH-1:0] final_res;
   logic             ovf;

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      carry_d  = carry_q;
      a_d      = a_q;
      bx_d     = bx_q;
      shadow_d = shadow_q;
      result_d = result_q;
      cflag_d  = cflag_q;
      vflag_d  = vflag_q;
      zflag_d  = zflag_q;
      nflag_d  = nflag_q;

      // Operands shift right each RUN cycle, so the active chunk is always the low CHUNK bits
      // and the result shadow fills from the top down.
      chunk_sum = {1'b0, a_q[CHUNK-1:0]} + {1'b0, bx_q[CHUNK-1:0]} + {{CHUNK{1'b0}}, carry_q};
      raw_sum   = (shadow_q >> CHUNK) | (WIDTH'(chunk_sum[CHUNK-1:0]) << (WIDTH - CHUNK));
      // On the last chunk the low slice holds the operand MSBs.
      ovf       = (a_q[CHUNK-1] == bx_q[CHUNK-1]) && (chunk_sum[CHUNK-1] != a_q[CHUNK-1]);
`ifdef ADDSUB_SATURATE_EN
      if (ovf) begin
         final_res = a_q[CHUNK-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
      end else begin
         final_res = raw_sum;
      end
`else
      final_res = raw_sum;
`endif

      unique case (state_q)
         StIdle: begin
            if (START) begin
               a_d     = A;
               bx_d    = B ^ {WIDTH{SUB}};
               carry_d = SUB;
               cnt_d   = '0;
               state_d = StRun;
            end
         end
         StRun: begin
            a_d      = a_q >> CHUNK;
            bx_d     = bx_q >> CHUNK;
            carry_d  = chunk_sum[CHUNK];
            shadow_d = raw_sum;
            cnt_d    = cnt_q + CNT_W'(1);
            if (cnt_q == LAST_CNT) begin
               state_d  = StFin;
               result_d = final_res;
               cflag_d  = chunk_sum[CHUNK];
               vflag_d  = ovf;
               zflag_d  = (final_res == '0);
               nflag_d  = final_res[WIDTH-1];
            end
         end
         StFin: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q  <= StIdle;
         cnt_q    <= '0;
         carry_q  <= 1'b0;
         a_q      <= '0;
         bx_q     <= '0;
         shadow_q <= '0;
         result_q <= '0;
         cflag_q  <= 1'b0;
         vflag_q  <= 1'b0;
         zflag_q  <= 1'b0;
         nflag_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         carry_q  <= carry_d;
         a_q      <= a_d;
         bx_q     <= bx_d;
         shadow_q <= shadow_d;
         result_q <= result_d;
         cflag_q  <= cflag_d;
         vflag_q  <= vflag_d;
         zflag_q  <= zflag_d;
         nflag_q  <= nflag_d;
      end
   end

   assign BUSY     = (state_q == StRun);
   assign DONE     = (state_q == StFin);
   assign RESULT   = result_q;
   assign CARRY    = cflag_q;
   assign OVERFLOW = vflag_q;
   assign ZERO     = zflag_q;
   assign NEGATIVE = nflag_q;

endmodule

// File: tb/tb_chunk_serial_addsub.sv
// Bench for chunk_serial_addsub: 32/8, 16/16 and 16/4 instances, directed table plus handshake
// sequences and a random regression against a full-width reference model.
module tb_chunk_serial_addsub;

   logic        CLK = 1'b0;
   logic        RST = 1'b0;
   logic        SUB = 1'b0;
   logic        st32 = 1'b0, st16 = 1'b0, st164 = 1'b0;
   logic [31:0] a32 = '0, b32 = '0;
   logic [15:0] a16 = '0, b16 = '0;

   logic        busy32, done32, c32, v32, z32, n32;
   logic [31:0] res32;
   logic        busy16, done16, c16, v16, z16, n16;
   logic [15:0] res16;
   logic        busy164, done164, c164, v164, z164, n164;
   logic [15:0] res164;

   int n_cmp  = 0;
   int n_fail = 0;

   always #5 CLK = ~CLK;

   chunk_serial_addsub #(.WIDTH(32), .CHUNK(8)) dut32 (
      .CLK(CLK), .RST(RST), .START(st32), .SUB(SUB), .A(a32), .B(b32),
      .BUSY(busy32), .DONE(done32), .RESULT(res32),
      .CARRY(c32), .OVERFLOW(v32), .ZERO(z32), .NEGATIVE(n32)
   );

   chunk_serial_addsub #(.WIDTH(16), .CHUNK(16)) dut16 (
      .CLK(CLK), .RST(RST), .START(st16), .SUB(SUB), .A(a16), .B(b16),
      .BUSY(busy16), .DONE(done16), .RESULT(res16),
      .CARRY(c16), .OVERFLOW(v16), .ZERO(z16), .NEGATIVE(n16)
   );

   chunk_serial_addsub #(.WIDTH(16), .CHUNK(4)) dut164 (
      .CLK(CLK), .RST(RST), .START(st164), .SUB(SUB), .A(a16), .B(b16),
      .BUSY(busy164), .DONE(done164), .RESULT(res164),
      .CARRY(c164), .OVERFLOW(v164), .ZERO(z164), .NEGATIVE(n164)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   function automatic logic get_busy(input int sel);
      case (sel)
         0:       return busy32;
         1:       return busy16;
         default: return busy164;
      endcase
   endfunction

   function automatic logic get_done(input int sel);
      case (sel)
         0:       return done32;
         1:       return done16;
         default: return done164;
      endcase
   endfunction

   function automatic logic [31:0] get_res(input int sel);
      case (sel)
         0:       return res32;
         1:       return {16'h0, res16};
         default: return {16'h0, res164};
      endcase
   endfunction

   function automatic logic [3:0] get_flags(input int sel);
      case (sel)
         0:       return {c32, v32, z32, n32};
         1:       return {c16, v16, z16, n16};
         default: return {c164, v164, z164, n164};
      endcase
   endfunction

   // Full-width reference: returns {C,V,Z,N, result}.
   function automatic logic [35:0] model(input int w, input logic sub,
                                         input logic [31:0] a, input logic [31:0] b);
      logic [63:0] m, bx, s, r;
      logic        c, v, am, bm;
      m  = (64'd1 << w) - 64'd1;
      bx = sub ? (~{32'd0, b}) & m : ({32'd0, b} & m);
      s  = ({32'd0, a} & m) + bx + {63'd0, sub};
      r  = s & m;
      c  = s[w];
      am = a[w-1];
      bm = bx[w-1];
      v  = (am == bm) && (r[w-1] != am);
`ifdef ADDSUB_SATURATE_EN
      if (v) r = am ? (64'd1 << (w - 1)) : ((64'd1 << (w - 1)) - 64'd1);
`endif
      return {c, v, (r == 64'd0), r[w-1], r[31:0]};
   endfunction

   task automatic run_op(input int sel, input logic sub, input logic [31:0] a,
                         input logic [31:0] b, output logic [31:0] res, output logic [3:0] f,
                         output int lat, output int busy_n);
      @(negedge CLK);
      SUB = sub; a32 = a; b32 = b; a16 = a[15:0]; b16 = b[15:0];
      st32 = (sel == 0); st16 = (sel == 1); st164 = (sel == 2);
      lat = 0; busy_n = 0; res = '0; f = '0;
      for (int i = 1; i <= 20; i++) begin
         @(negedge CLK);
         st32 = 1'b0; st16 = 1'b0; st164 = 1'b0;
         if (get_busy(sel)) busy_n++;
         if (get_done(sel)) begin
            lat = i;
            res = get_res(sel);
            f   = get_flags(sel);
            check("busy_at_done", {63'd0, get_busy(sel)}, 64'd0);
            break;
         end
      end
      @(negedge CLK);
      check("done_one_cycle", {63'd0, get_done(sel)}, 64'd0);
   endtask

   typedef struct {
      logic        sub;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] res;
      logic [3:0]  cvzn;
   } vec_t;

   vec_t        vecs[8];
   logic [31:0] r;
   logic [3:0]  f;
   logic [35:0] exp_m;
   int          lat, busy_n, done_n;
   logic        sub_r;
   logic [31:0] ra, rb;
   logic        busy_log[13];
   logic        done_log[13];

   initial begin
      vecs[0] = '{1'b0, 32'h0000_00FF, 32'h0000_0001, 32'h0000_0100, 4'b0000};
      vecs[1] = '{1'b1, 32'h0000_0005, 32'h0000_0005, 32'h0000_0000, 4'b1010};
      vecs[2] = '{1'b1, 32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 4'b0001};
`ifdef ADDSUB_SATURATE_EN
      vecs[3] = '{1'b0, 32'h7FFF_FFFF, 32'h0000_0001, 32'h7FFF_FFFF, 4'b0100};
      vecs[4] = '{1'b1, 32'h8000_0000, 32'h0000_0001, 32'h8000_0000, 4'b1101};
`else
      vecs[3] = '{1'b0, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 4'b0101};
      vecs[4] = '{1'b1, 32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 4'b1100};
`endif
      vecs[5] = '{1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 4'b1001};
      vecs[6] = '{1'b0, 32'h1234_5678, 32'h9ABC_DEF0, 32'hACF1_3568, 4'b0001};
      vecs[7] = '{1'b1, 32'h0001_0000, 32'h0000_FFFF, 32'h0000_0001, 4'b1000};

      RST = 1'b1;
      repeat (2) @(negedge CLK);
      check("reset_outputs_32", {busy32, done32, res32, c32, v32, z32, n32}, 64'd0);
      check("reset_outputs_16", {busy16, done16, res16, c16, v16, z16, n16}, 64'd0);
      RST = 1'b0;

      for (int i = 0; i < 8; i++) begin
         run_op(0, vecs[i].sub, vecs[i].a, vecs[i].b, r, f, lat, busy_n);
         check($sformatf("vec%0d_result", i), {32'd0, r}, {32'd0, vecs[i].res});
         check($sformatf("vec%0d_cvzn", i), {60'd0, f}, {60'd0, vecs[i].cvzn});
         check($sformatf("vec%0d_latency", i), lat, 5);
         check($sformatf("vec%0d_busy_cycles", i), busy_n, 4);
      end

      // NCHUNK = 1 corners
      run_op(1, 1'b0, 32'h0000_FFFF, 32'h0000_0001, r, f, lat, busy_n);
      check("w16c16_add_result", {32'd0, r}, 64'h0);
      check("w16c16_add_cvzn", {60'd0, f}, 64'b1010);
      check("w16c16_latency", lat, 2);
      check("w16c16_busy_cycles", busy_n, 1);
      run_op(1, 1'b1, 32'h0000_8000, 32'h0000_0001, r, f, lat, busy_n);
`ifdef ADDSUB_SATURATE_EN
      check("w16c16_sub_result", {32'd0, r}, 64'h8000);
      check("w16c16_sub_cvzn", {60'd0, f}, 64'b1101);
`else
      check("w16c16_sub_result", {32'd0, r}, 64'h7FFF);
      check("w16c16_sub_cvzn", {60'd0, f}, 64'b1100);
`endif

      // START pulses and operand changes during RUN are ignored
      @(negedge CLK);
      SUB = 1'b0; a32 = 32'd3; b32 = 32'd4; st32 = 1'b1;
      @(negedge CLK);
      st32 = 1'b0; SUB = 1'b1; a32 = 32'hDEAD_BEEF; b32 = 32'h1111_1111;
      @(negedge CLK);
      st32 = 1'b1;
      @(negedge CLK);
      st32 = 1'b0;
      lat = 0;
      for (int i = 3; i <= 20; i++) begin
         if (done32) begin
            lat = i;
            break;
         end
         @(negedge CLK);
      end
      check("ignore_run_latency", lat, 5);
      check("ignore_run_result", {32'd0, res32}, 64'd7);
      done_n = 0;
      for (int i = 0; i < 6; i++) begin
         @(negedge CLK);
         if (busy32 || done32) done_n++;
      end
      check("ignore_run_no_second_op", done_n, 0);

      // Reset in the 2nd RUN cycle aborts the operation
      run_op(0, 1'b1, 32'h0, 32'h1, r, f, lat, busy_n);
      check("pre_abort_result", {32'd0, r}, 64'hFFFF_FFFF);
      @(negedge CLK);
      SUB = 1'b0; a32 = 32'd100; b32 = 32'd23; st32 = 1'b1;
      @(negedge CLK);
      st32 = 1'b0;
      @(negedge CLK);
      RST = 1'b1;
      @(negedge CLK);
      check("abort_outputs", {busy32, done32, res32, c32, v32, z32, n32}, 64'd0);
      RST = 1'b0;
      done_n = 0;
      for (int i = 0; i < 8; i++) begin
         @(negedge CLK);
         if (done32) done_n++;
      end
      check("abort_no_done", done_n, 0);
      check("abort_result_held_zero", {32'd0, res32}, 64'd0);
      run_op(0, 1'b0, 32'd100, 32'd23, r, f, lat, busy_n);
      check("post_abort_result", {32'd0, r}, 64'd123);
      check("post_abort_latency", lat, 5);

      // START held through FIN: accepted at the IDLE edge after DONE
      @(negedge CLK);
      SUB = 1'b0; a32 = 32'd1; b32 = 32'd1; st32 = 1'b1;
      for (int i = 1; i <= 12; i++) begin
         @(negedge CLK);
         if (i == 1) begin
            a32 = 32'd10;
            b32 = 32'd20;
         end
         busy_log[i] = busy32;
         done_log[i] = done32;
         if (i == 5) check("held_first_result", {32'd0, res32}, 64'd2);
         if (i == 11) check("held_second_result", {32'd0, res32}, 64'd30);
         if (i == 7) st32 = 1'b0;
      end
      check("held_done_cycle5", {63'd0, done_log[5]}, 64'd1);
      check("held_idle_cycle6", {62'd0, busy_log[6], done_log[6]}, 64'd0);
      check("held_busy_cycle7", {63'd0, busy_log[7]}, 64'd1);
      check("held_done_cycle11", {63'd0, done_log[11]}, 64'd1);

      // Random regression against the reference model
      for (int i = 0; i < 30; i++) begin
         ra = $urandom; rb = $urandom; sub_r = 1'($urandom_range(0, 1));
         exp_m = model(32, sub_r, ra, rb);
         run_op(0, sub_r, ra, rb, r, f, lat, busy_n);
         check($sformatf("rnd32_%0d_%0h_%0h_%0b", i, ra, rb, sub_r),
               {28'd0, f, r}, {28'd0, exp_m});
      end
      for (int i = 0; i < 30; i++) begin
         ra = {16'd0, 16'($urandom)}; rb = {16'd0, 16'($urandom)};
         sub_r = 1'($urandom_range(0, 1));
         exp_m = model(16, sub_r, ra, rb);
         run_op(2, sub_r, ra, rb, r, f, lat, busy_n);
         check($sformatf("rnd16x4_%0d_%0h_%0h_%0b", i, ra, rb, sub_r),
               {28'd0, f, r}, {28'd0, exp_m});
         if (i == 0) check("w16c4_latency", lat, 5);
      end
      for (int i = 0; i < 10; i++) begin
         ra = {16'd0, 16'($urandom)}; rb = {16'd0, 16'($urandom)};
         sub_r = 1'($urandom_range(0, 1));
         exp_m = model(16, sub_r, ra, rb);
         run_op(1, sub_r, ra, rb, r, f, lat, busy_n);
         check($sformatf("rnd16x16_%0d_%0h_%0h_%0b", i, ra, rb, sub_r),
               {28'd0, f, r}, {28'd0, exp_m});
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
